// File: rtl/sseg_capture.sv
// sseg_capture: reconstructs the hex nibble shown on each digit of a scanned active-low
// seven-segment display, with synchronisation, a stability filter and per-digit flags.
module sseg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              sseg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   valid_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    frame_done
);
  localparam int W  = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

  logic [W-1:0]            s1_q, s2_q, s3_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d, err_q, err_d, seen_q, seen_d;
  logic                    frame_q, frame_d;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    changed, one_hot, capture, blank;
  logic [4:0]              glyph;

  assign changed = s2_q != s3_q;
  assign an_n    = ~s2_q[W-1:7];
  assign one_hot = (an_n != '0) && ((an_n & (an_n - 1'b1)) == '0);
  assign blank   = &s2_q[6:0];

  // {legal, value}; patterns are abcdefg with a in bit 6, segment on = 0
  always_comb begin
    case (s2_q[6:0])
      7'b0000001: glyph = 5'h10;
      7'b1001111: glyph = 5'h11;
      7'b0010010: glyph = 5'h12;
      7'b0000110: glyph = 5'h13;
      7'b1001100: glyph = 5'h14;
      7'b0100100: glyph = 5'h15;
      7'b0100000: glyph = 5'h16;
      7'b0001111: glyph = 5'h17;
      7'b0000000: glyph = 5'h18;
      7'b0000100: glyph = 5'h19;
      7'b0001000: glyph = 5'h1a;
      7'b1100000: glyph = 5'h1b;
      7'b0110001: glyph = 5'h1c;
      7'b1000010: glyph = 5'h1d;
      7'b0110000: glyph = 5'h1e;
      7'b0111000: glyph = 5'h1f;
      default:    glyph = 5'h00;
    endcase
  end

  always_comb begin
    cnt_d    = changed ? '0 : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1);
    capture  = !changed && cnt_q == CNT_CAP && !done_q && one_hot;
    done_d   = !changed && (done_q || capture);
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    seen_d   = seen_q;
    frame_d  = 1'b0;
    if (clr) begin
      digits_d = '0;
      valid_d  = '0;
      err_d    = '0;
      seen_d   = '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (an_n[i]) begin
          if (glyph[4]) digits_d[4*i +: 4] = glyph[3:0];
          valid_d[i] = glyph[4];
          err_d[i]   = !glyph[4] && !blank;
          seen_d[i]  = 1'b1;
        end
      end
      // the completing capture both pulses the strobe and opens a fresh frame
      if (&seen_d) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '1;
      s2_q     <= '1;
      s3_q     <= '1;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
    end else begin
      s1_q     <= {an_in, sseg_in};
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
    end
  end

  assign digits_out = digits_q;
  assign valid_out  = valid_q;
  assign err_out    = err_q;
  assign frame_done = frame_q;
endmodule

// File: tb/tb_sseg_capture.sv
// tb_sseg_capture: vector table, directed corner sequences and random scanning,
// all cross-checked every cycle against a run-length reference model.
module tb_sseg_capture;
  localparam int N = 4;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic [6:0]   sseg_in = 7'h7f;
  logic [N-1:0] an_in = 4'b1110;
  logic [15:0]  digits_out, d1_digits;
  logic [N-1:0] valid_out, err_out, d1_valid, d1_err;
  logic         frame_done, d1_frame;

  sseg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .sseg_in(sseg_in), .an_in(an_in), .clr(clr),
    .digits_out(digits_out), .valid_out(valid_out), .err_out(err_out), .frame_done(frame_done));

  sseg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .sseg_in(sseg_in), .an_in(an_in), .clr(clr),
    .digits_out(d1_digits), .valid_out(d1_valid), .err_out(d1_err), .frame_done(d1_frame));

  always #5 clk = ~clk;

  logic [6:0] gl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int checks = 0, failures = 0, fcnt = 0, fstep = 0;

  // reference model: capture fires when the sample taken two edges ago closes a run of S+1
  logic [10:0]  vq [3];
  int           rq [3];
  int           run;
  logic [15:0]  m_dig;
  logic [N-1:0] m_val, m_err, m_seen;
  logic         m_frame;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      vq[i] = '1;
      rq[i] = 1;
    end
    run = 1; m_dig = '0; m_val = '0; m_err = '0; m_seen = '0; m_frame = 1'b0;
  endtask

  task automatic model_edge();
    logic [10:0] v;
    logic [N-1:0] a;
    int hit;
    if (!rst) begin
      model_reset();
      return;
    end
    v = {an_in, sseg_in};
    run = (v == vq[0]) ? run + 1 : 1;
    vq[2] = vq[1]; vq[1] = vq[0]; vq[0] = v;
    rq[2] = rq[1]; rq[1] = rq[0]; rq[0] = run;
    m_frame = 1'b0;
    a = ~vq[2][10:7];
    if (clr) begin
      m_dig = '0; m_val = '0; m_err = '0; m_seen = '0;
    end else if (rq[2] == S + 1 && $countones(a) == 1) begin
      hit = -1;
      for (int k = 0; k < 16; k++) if (gl[k] == vq[2][6:0]) hit = k;
      for (int i = 0; i < N; i++) begin
        if (a[i]) begin
          if (hit >= 0) m_dig[4*i +: 4] = 4'(hit);
          m_val[i] = hit >= 0;
          m_err[i] = hit < 0 && vq[2][6:0] != 7'h7f;
          m_seen[i] = 1'b1;
        end
      end
      if (&m_seen) begin
        m_frame = 1'b1;
        m_seen = '0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (frame_done) fcnt++;
    chk("model", {39'd0, digits_out, valid_out, err_out, frame_done},
        {39'd0, m_dig, m_val, m_err, m_frame});
  endtask

  task automatic show(input int d, input logic [6:0] p);
    an_in = ~(4'(1) << d);
    sseg_in = p;
  endtask

  typedef struct {
    int d; logic [6:0] pat; logic [3:0] val; logic v; logic e;
  } vec_t;
  vec_t tbl [20];

  initial begin
    tbl = '{'{0, 7'b0000001, 4'h0, 1, 0}, '{1, 7'b1100000, 4'hb, 1, 0},
            '{2, 7'b0110000, 4'he, 1, 0}, '{3, 7'b0000100, 4'h9, 1, 0},
            '{0, 7'b1111110, 4'h0, 0, 1}, '{0, 7'b1111111, 4'h0, 0, 0},
            '{1, 7'b0000000, 4'h8, 1, 0}, '{1, 7'b0100111, 4'h8, 0, 1},
            '{2, 7'b0110001, 4'hc, 1, 0}, '{3, 7'b0001000, 4'ha, 1, 0},
            '{3, 7'b1111111, 4'ha, 0, 0}, '{2, 7'b1000010, 4'hd, 1, 0},
            '{0, 7'b0100100, 4'h5, 1, 0}, '{1, 7'b0010010, 4'h2, 1, 0},
            '{0, 7'b0100000, 4'h6, 1, 0}, '{3, 7'b0001111, 4'h7, 1, 0},
            '{2, 7'b0000110, 4'h3, 1, 0}, '{1, 7'b1001111, 4'h1, 1, 0},
            '{0, 7'b0111000, 4'hf, 1, 0}, '{3, 7'b1001100, 4'h4, 1, 0}};
    model_reset();
    an_in = 4'b1110;
    sseg_in = 7'b1001111;
    repeat (3) step();
    chk("reset_outs", {digits_out, valid_out, err_out, frame_done}, 25'd0);
    rst = 1'b1;
    repeat (3) step();
    chk("s1_before", 64'(d1_valid), 64'(4'b0000));
    step();
    chk("s1_capture", 64'({d1_digits, d1_valid}), 64'({16'h0001, 4'b0001}));
    repeat (2) step();
    chk("lat_before", 64'(valid_out), 64'(4'b0000));
    step();
    chk("lat_capture", {digits_out, valid_out, err_out, frame_done}, {16'h0001, 4'b0001, 4'b0000, 1'b0});
    chk("no_frame_reset", 64'(fcnt), 64'd0);

    fcnt = 0;
    for (int d = 0; d < 4; d++) begin
      show(d, d == 0 ? gl[7] : d == 1 ? gl[10] : d == 2 ? gl[0] : gl[15]);
      for (int s = 1; s <= 8; s++) begin
        step();
        if (d == 3 && frame_done) fstep = s;
      end
    end
    chk("scan_digits", {digits_out, valid_out}, {16'hF0A7, 4'b1111});
    chk("scan_frames", 64'(fcnt), 64'd1);
    chk("scan_frame_edge", 64'(fstep), 64'(S + 3));

    show(1, gl[10]);
    repeat (8) step();
    sseg_in = 7'b0111111;
    repeat (2) step();
    sseg_in = gl[10];
    repeat (8) step();
    chk("ghost", {digits_out[7:4], err_out[1], valid_out[1]}, {4'hA, 1'b0, 1'b1});

    show(2, 7'b1111110);
    repeat (6) step();
    sseg_in = 7'h7f;
    step();
    chk("err_digit", {digits_out, valid_out, err_out}, {16'hF0A7, 4'b1011, 4'b0100});
    repeat (8) step();
    chk("blank_digit", {digits_out, valid_out, err_out}, {16'hF0A7, 4'b1011, 4'b0000});

    an_in = 4'b1100;
    sseg_in = gl[8];
    fcnt = 0;
    repeat (10) step();
    chk("bad_anode", {digits_out, valid_out, err_out}, {16'hF0A7, 4'b1011, 4'b0000});

    show(0, gl[3]);
    repeat (S + 2) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_prio", {digits_out, valid_out, err_out, frame_done}, 25'd0);
    repeat (10) step();
    chk("clr_no_recap", {digits_out, valid_out, err_out, frame_done}, 25'd0);

    show(1, gl[4]);
    repeat (50) step();
    chk("hold_capture", {digits_out, valid_out, err_out}, {16'h0040, 4'b0010, 4'b0000});
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (49) step();
    chk("hold_once", {digits_out, valid_out, err_out, frame_done}, 25'd0);
    chk("hold_frames", 64'(fcnt), 64'd0);

    show(2, gl[6]);
    repeat (8) step();
    show(3, gl[9]);
    repeat (3) step();
    chk("pre_async", {digits_out, valid_out}, {16'h0600, 4'b0100});
    #2 rst = 1'b0;
    #1 chk("async_rst", {digits_out, valid_out, err_out, frame_done}, 25'd0);
    model_reset();
    #2 rst = 1'b1;

    for (int t = 0; t < 20; t++) begin
      show(tbl[t].d, tbl[t].pat);
      repeat (S + 4) step();
      chk($sformatf("vec%0d", t), {digits_out[4*tbl[t].d +: 4], valid_out[tbl[t].d], err_out[tbl[t].d]},
          {tbl[t].val, tbl[t].v, tbl[t].e});
    end

    for (int k = 0; k < 400; k++) begin
      int d, r, hold;
      d = $urandom_range(N - 1, 0);
      r = $urandom_range(99, 0);
      show(d, gl[$urandom_range(15, 0)]);
      if (r >= 60 && r < 75) sseg_in = 7'h7f;
      else if (r >= 75 && r < 90) sseg_in = 7'($urandom);
      else if (r >= 90) an_in = 4'($urandom);
      hold = $urandom_range(9, 1);
      repeat (hold) begin
        clr = ($urandom_range(19, 0) == 0);
        step();
      end
      clr = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
